dram_port_arbiter: RTL and testbench
====================================

# dram_port_arbiter

Round-robin arbiter that shares one single-port DRAM access channel among `NUM_CORES` core requesters. It removes same-cycle write conflicts on the shared `ram` array by serialising every core access into exactly one memory transaction at a time. Each core sees a simple req/done handshake. The block sits between the core load/store units and the DRAM, driving the DRAM's address, data and write-enable pins and consuming its registered read data.

## Interface
Parameters:
- `NUM_CORES`, 4: number of requesters; must be ≥2.
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.
- `MEM_DEPTH`, 1025: valid addresses are 0..MEM_DEPTH-1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  NUM_CORES  per-core request level.
- `we`  in  NUM_CORES  per-core write flag; 1 = write, 0 = read.
- `addr`  in  NUM_CORES*ADDR_W  per-core address; core i uses slice [i*ADDR_W +: ADDR_W].
- `wdata`  in  NUM_CORES*DATA_W  per-core write data, sliced the same way.
- `done`  out  NUM_CORES  one-hot, one-cycle completion pulse.
- `rdata`  out  DATA_W  read data; valid while `done` is nonzero.
- `err`  out  1  out-of-range flag; valid while `done` is nonzero.
- `busy`  out  1  high in any state except IDLE.
- `mem_we`  out  1  DRAM write enable.
- `mem_addr`  out  ADDR_W  DRAM address.
- `mem_wdata`  out  DATA_W  DRAM write data.
- `mem_rdata`  in  DATA_W  DRAM read data, registered one cycle after the address.

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- **IDLE**
  - If any `req` bit is set, pick the winner by round-robin, starting at `last_gnt+1` and wrapping modulo NUM_CORES.
  - Latch the winner index and its `we`, `addr` and `wdata`, then go to ACCESS.
  - If no `req` bit is set, stay in IDLE.
- **ACCESS** (exactly 1 cycle)
  - Drive `mem_addr` and `mem_wdata` from the latched values.
  - `mem_we` = latched we AND address in range.
  - Update `last_gnt` to the winner index.
  - Write goes to DONE; read goes to WAIT.
- **WAIT** (read only, 1 cycle)
  - Capture `mem_rdata` into the `rdata` register at the end of the cycle.
  - Go to DONE.
- **DONE** (1 cycle)
  - Assert `done[winner]`; `rdata` and `err` are valid.
  - Return to IDLE.
- **Core contract**
  - Hold `req`, `we`, `addr` and `wdata` stable from assertion through the DONE cycle.
  - Deassert `req` on the clock edge that ends the DONE cycle.
  - A core that keeps `req` high is treated as a new request and is re-arbitrated normally.
- **Out-of-range address** (addr ≥ MEM_DEPTH)
  - No write is performed.
  - A read returns `rdata` = 0.
  - `err` = 1 in the DONE cycle; `err` = 0 otherwise.
- `req` changes outside IDLE are ignored; only IDLE samples requests.
- **Write data in non-write cycles**: `mem_wdata` holds its last latched value; `mem_we` is 0 in every state except ACCESS.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - state = IDLE, `last_gnt` = NUM_CORES-1 (so core 0 wins first);
  - `done` = 0, `rdata` = 0, `err` = 0, `busy` = 0;
  - `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Request sampled in IDLE at cycle T:
  - Write: `mem_we` high in T+1, `done` in T+2. Occupancy 3 cycles.
  - Read: address on `mem_addr` in T+1, `mem_rdata` valid in T+2, `done` and `rdata` in T+3. Occupancy 4 cycles.
- Worst-case wait for a continuously requesting core: (NUM_CORES-1) × 4 cycles plus its own transaction.
- **Reset mid-transaction**: any in-flight write whose ACCESS cycle has not completed is dropped. No `done` is issued. Arbitration restarts at core 0.
- **Simultaneous requests**: exactly one grant per transaction. Losing requests stay pending with no timeout.
- All outputs are registered; there are no combinational paths from `req` to any output.

## Structure
- Package `dram_arb_pkg`:
  - state enum {IDLE, ACCESS, WAIT, DONE};
  - default width constants;
  - `MEM_DEPTH` default.
- Sub-module `rr_select`, combinational:
  - inputs: `req` vector and `last_gnt`;
  - outputs: `gnt_valid` and `gnt_idx`, using a rotate-and-priority-encode scheme.
- `dram_port_arbiter` instantiates `rr_select` and holds the FSM, latches and output registers.

## Test plan
- Reset, then core 0 writes 0x0055 to addr 10 → `mem_we`=1 with `mem_addr`=10 at T+1; `done`=4'b0001 at T+2; `err`=0.
- Core 2 reads addr 10 after that write → `done`=4'b0100 at T+3 and `rdata`=0x0055.
- All four cores write addr 5 (data 0x11/0x22/0x33/0x44) in the same cycle from reset → grants in order 0,1,2,3; a final read of addr 5 returns 0x0044; no two `mem_we` cycles overlap.
- Cores 1 and 3 hold `req` continuously for 20 transactions → grants alternate 1,3,1,3; neither core waits more than 4 cycles beyond its own occupancy.
- Core 0 reads addr 2000 → no `mem_we`; `rdata`=0 and `err`=1 in the DONE cycle.
- `rst_n` pulsed low during a write's ACCESS cycle → `mem_we` drops immediately; no `done`; the next grant goes to core 0.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types and default sizing for the DRAM port arbiter.
package dram_arb_pkg;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_MEM_DEPTH = 1025;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/dram_port_arbiter_rr_select.sv
// Round-robin winner selection: rotate the request vector so the core after
// last_gnt sits at bit 0, priority-encode the lowest set bit, rotate back.
module rr_select #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     last_gnt,
  output logic                 gnt_valid,
  output logic [IDX_W-1:0]     gnt_idx
);

  logic [31:0]          start_idx;
  logic [NUM_CORES-1:0] rot;
  logic [31:0]          pos;

  // Rotate, find first requester, map back to an absolute core index.
  always_comb begin
    start_idx = (32'(last_gnt) + 32'd1) % 32'(NUM_CORES);
    rot       = NUM_CORES'({req, req} >> start_idx);
    gnt_valid = |rot;
    pos       = '0;
    for (int unsigned i = NUM_CORES; i > 0; i--) begin
      if (rot[i-1]) pos = 32'(i - 1);
    end
    gnt_idx = IDX_W'((start_idx + pos) % 32'(NUM_CORES));
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Serialises NUM_CORES req/done core ports onto one single-port DRAM channel.
// One transaction at a time: IDLE -> ACCESS -> (WAIT for reads) -> DONE.
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        we,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  input  logic [NUM_CORES*DATA_W-1:0] wdata,
  output logic [NUM_CORES-1:0]        done,
  output logic [DATA_W-1:0]           rdata,
  output logic                        err,
  output logic                        busy,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int                IDX_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_CORES - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      last_gnt_q, last_gnt_d;
  logic [IDX_W-1:0]      win_q, win_d;
  logic                  we_q, we_d;
  logic                  oor_q, oor_d;
  logic [NUM_CORES-1:0]  done_q, done_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;

  logic                  gnt_valid;
  logic [IDX_W-1:0]      gnt_idx;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic                  sel_oor;

  rr_select #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_rr_select (
    .req       (req),
    .last_gnt  (last_gnt_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign sel_addr  = addr[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_wdata = wdata[gnt_idx*DATA_W +: DATA_W];
  assign sel_oor   = ({1'b0, sel_addr} >= DEPTH_X);

  // The latched address/data live directly in the mem_addr/mem_wdata
  // registers, which is why those hold their value outside ACCESS.
  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    win_d       = win_q;
    we_d        = we_q;
    oor_d       = oor_q;
    done_d      = '0;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d     = ACCESS;
          win_d       = gnt_idx;
          we_d        = we[gnt_idx];
          oor_d       = sel_oor;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          mem_we_d    = we[gnt_idx] & ~sel_oor;
        end
      end
      ACCESS: begin
        last_gnt_d = win_q;
        if (we_q) begin
          state_d       = DONE;
          done_d[win_q] = 1'b1;
          err_d         = oor_q;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        rdata_d       = oor_q ? '0 : mem_rdata;
        state_d       = DONE;
        done_d[win_q] = 1'b1;
        err_d         = oor_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM state and arbitration history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= LAST_RST;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Transaction latches and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q       <= '0;
      we_q        <= 1'b0;
      oor_q       <= 1'b0;
      done_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      win_q       <= win_d;
      we_q        <= we_d;
      oor_q       <= oor_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign done      = done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter with a registered-read DRAM model.
module tb_dram_port_arbiter;

  localparam int NC    = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 1025;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0]     req;
  logic [NC-1:0]     we;
  logic [NC*AW-1:0]  addr;
  logic [NC*DW-1:0]  wdata;
  logic [NC-1:0]     done;
  logic [DW-1:0]     rdata;
  logic              err;
  logic              busy;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata = '0;

  logic [DW-1:0]     ram [0:DEPTH-1] = '{default: '0};

  int total = 0;
  int bad   = 0;

  dram_port_arbiter #(
    .NUM_CORES (NC),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .busy      (busy),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port DRAM: write on mem_we, read data registered one cycle later.
  always @(posedge clk) begin
    if (int'(mem_addr) < DEPTH) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end else begin
      mem_rdata <= '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_core(input int c, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[c]           = r;
    we[c]            = w;
    addr[c*AW +: AW] = a;
    wdata[c*DW +: DW] = d;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    int dcnt;
    int dcyc [20];
    logic [NC-1:0] dval [20];
    int wepulses;
    int overlap;
    logic prev_we;
    int exp_c3 [4];
    logic [NC-1:0] exp_d3 [4];

    exp_c3 = '{2, 5, 8, 11};
    exp_d3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    rst_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    repeat (2) step();

    // Reset state
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    step();

    // Core 0 writes 0x0055 to addr 10
    set_core(0, 1'b1, 1'b1, 16'd10, 16'h0055);
    step();
    chk("w0_mem_we", 32'(mem_we), 32'h1);
    chk("w0_mem_addr", 32'(mem_addr), 32'd10);
    chk("w0_mem_wdata", 32'(mem_wdata), 32'h55);
    chk("w0_busy", 32'(busy), 32'h1);
    chk("w0_early_done", 32'(done), 32'h0);
    step();
    chk("w0_done", 32'(done), 32'b0001);
    chk("w0_err", 32'(err), 32'h0);
    chk("w0_we_off", 32'(mem_we), 32'h0);
    set_core(0, 1'b0, 1'b0, 16'd0, 16'h0);
    step();
    chk("w0_idle_done", 32'(done), 32'h0);
    chk("w0_idle_busy", 32'(busy), 32'h0);

    // Core 2 reads addr 10
    set_core(2, 1'b1, 1'b0, 16'd10, 16'h0);
    step();
    chk("r2_mem_we", 32'(mem_we), 32'h0);
    chk("r2_mem_addr", 32'(mem_addr), 32'd10);
    step();
    chk("r2_wait_done", 32'(done), 32'h0);
    step();
    chk("r2_done", 32'(done), 32'b0100);
    chk("r2_rdata", 32'(rdata), 32'h55);
    chk("r2_err", 32'(err), 32'h0);
    set_core(2, 1'b0, 1'b0, 16'd0, 16'h0);
    step();

    // All four cores write addr 5 together, fresh from reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    set_core(0, 1'b1, 1'b1, 16'd5, 16'h0011);
    set_core(1, 1'b1, 1'b1, 16'd5, 16'h0022);
    set_core(2, 1'b1, 1'b1, 16'd5, 16'h0033);
    set_core(3, 1'b1, 1'b1, 16'd5, 16'h0044);
    dcnt = 0; wepulses = 0; overlap = 0; prev_we = 1'b0;
    for (int c = 1; c <= 40 && dcnt < 4; c++) begin
      step();
      if (mem_we) begin
        wepulses++;
        if (prev_we) overlap++;
      end
      prev_we = mem_we;
      if (done != '0) begin
        dval[dcnt] = done;
        dcyc[dcnt] = c;
        dcnt++;
        for (int k = 0; k < NC; k++) if (done[k]) req[k] = 1'b0;
      end
    end
    chk("all4_count", 32'(dcnt), 32'd4);
    for (int i = 0; i < dcnt; i++) begin
      chk($sformatf("all4_done%0d", i), 32'(dval[i]), 32'(exp_d3[i]));
      chk($sformatf("all4_cyc%0d", i), 32'(dcyc[i]), 32'(exp_c3[i]));
    end
    chk("all4_we_pulses", 32'(wepulses), 32'd4);
    chk("all4_we_overlap", 32'(overlap), 32'd0);
    step();
    set_core(0, 1'b1, 1'b0, 16'd5, 16'h0);
    repeat (3) step();
    chk("all4_rd_done", 32'(done), 32'b0001);
    chk("all4_rd_data", 32'(rdata), 32'h44);
    set_core(0, 1'b0, 1'b0, 16'd0, 16'h0);
    step();

    // Cores 1 and 3 hold req continuously for 20 transactions
    set_core(1, 1'b1, 1'b1, 16'd100, 16'h00A1);
    set_core(3, 1'b1, 1'b1, 16'd101, 16'h00A3);
    dcnt = 0;
    for (int c = 1; c <= 200 && dcnt < 20; c++) begin
      step();
      if (done != '0) begin
        dval[dcnt] = done;
        dcyc[dcnt] = c;
        dcnt++;
      end
    end
    req = '0;
    chk("hold_count", 32'(dcnt), 32'd20);
    for (int i = 0; i < dcnt; i++) begin
      chk($sformatf("hold_done%0d", i), 32'(dval[i]), (i % 2 == 0) ? 32'b0010 : 32'b1000);
      chk($sformatf("hold_cyc%0d", i), 32'(dcyc[i]), 32'(2 + 3 * i));
    end
    step();

    // Core 0 reads out-of-range addr 2000
    set_core(0, 1'b1, 1'b0, 16'd2000, 16'h0);
    step();
    chk("oor_mem_we", 32'(mem_we), 32'h0);
    chk("oor_mem_addr", 32'(mem_addr), 32'd2000);
    step();
    chk("oor_wait_err", 32'(err), 32'h0);
    step();
    chk("oor_done", 32'(done), 32'b0001);
    chk("oor_rdata", 32'(rdata), 32'h0);
    chk("oor_err", 32'(err), 32'h1);
    set_core(0, 1'b0, 1'b0, 16'd0, 16'h0);
    step();
    chk("oor_err_clear", 32'(err), 32'h0);
    chk("oor_done_clear", 32'(done), 32'h0);

    // Reset during a write's ACCESS cycle
    set_core(1, 1'b1, 1'b1, 16'd7, 16'h1234);
    repeat (2) step();
    chk("pre7_done", 32'(done), 32'b0010);
    set_core(1, 1'b0, 1'b0, 16'd0, 16'h0);
    step();
    set_core(2, 1'b1, 1'b1, 16'd7, 16'h0077);
    step();
    chk("rstw_mem_we", 32'(mem_we), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_we_drop", 32'(mem_we), 32'h0);
    chk("rstw_busy_drop", 32'(busy), 32'h0);
    set_core(2, 1'b0, 1'b0, 16'd0, 16'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rstw_no_done%0d", i), 32'(done), 32'h0);
    end
    set_core(0, 1'b1, 1'b1, 16'd9, 16'h0099);
    set_core(2, 1'b1, 1'b1, 16'd8, 16'h0088);
    step();
    chk("rstw_first_addr", 32'(mem_addr), 32'd9);
    step();
    chk("rstw_first_done", 32'(done), 32'b0001);
    set_core(0, 1'b0, 1'b0, 16'd0, 16'h0);
    repeat (2) step();
    chk("rstw_second_addr", 32'(mem_addr), 32'd8);
    step();
    chk("rstw_second_done", 32'(done), 32'b0100);
    set_core(2, 1'b0, 1'b0, 16'd0, 16'h0);
    step();
    set_core(1, 1'b1, 1'b0, 16'd7, 16'h0);
    repeat (3) step();
    chk("rstw_rd_done", 32'(done), 32'b0010);
    chk("rstw_rd_data", 32'(rdata), 32'h1234);
    set_core(1, 1'b0, 1'b0, 16'd0, 16'h0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
